// File: rtl/router_fsm.sv
// router_fsm: input-side packet controller of the 1x3 router.
// Decodes the header {len, addr}, waits for the target FIFO to drain, then
// steers header, payload and parity bytes into that FIFO. The source is held
// off with busy while the FSM cannot take a byte.
// Optional feature macro: PARITY_CHECK_EN. When it is defined, parity is
// accumulated and checked and err is driven. When it is undefined, err is
// tied low and the packet completes on the parity-accept cycle.
//
// Handshake: a source byte is transferred on a rising clk edge where
// pkt_valid=1 and busy=0. The source must hold data_in stable while busy=1.
// A FIFO write happens in the cycle where wt_en is high. dout is 0 otherwise.
module router_fsm #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pkt_valid,
    input  logic [DATA_W-1:0] data_in,
    input  logic [2:0]        fifo_empty,
    input  logic [2:0]        fifo_full,
    input  logic [2:0]        soft_rst,
    output logic [2:0]        wt_en,
    output logic [DATA_W-1:0] dout,
    output logic              lfd_state,
    output logic              busy,
    output logic              err,
    output logic              pkt_done
);

    localparam int LEN_W = DATA_W - 2;

    typedef enum logic [2:0] {
        DECODE_ADDRESS  = 3'd0,
        WAIT_TILL_EMPTY = 3'd1,
        LOAD_FIRST_DATA = 3'd2,
        LOAD_DATA       = 3'd3,
        LOAD_PARITY     = 3'd4,
        CHECK_PARITY    = 3'd5
    } state_t;

    state_t state;
    state_t state_nx;

    logic [DATA_W-1:0] hdr_q;
    logic [LEN_W-1:0]  cnt_q;
    logic [1:0]        addr_q;
    logic [1:0]        hdr_addr;

    logic wr;        // a byte goes to FIFO addr_q this cycle
    logic load_hdr;  // header accepted in DECODE_ADDRESS
    logic dec_cnt;   // payload byte accepted

    logic soft_hit;
    logic full_hit;

    // Address 3 has no FIFO: picking its flag yields 0.
    function automatic logic pick(input logic [2:0] v, input logic [1:0] i);
        case (i)
            2'd0:    pick = v[0];
            2'd1:    pick = v[1];
            2'd2:    pick = v[2];
            default: pick = 1'b0;
        endcase
    endfunction

    assign addr_q   = hdr_q[1:0];
    assign hdr_addr = data_in[1:0];
    assign soft_hit = pick(soft_rst, addr_q);
    assign full_hit = pick(fifo_full, addr_q);

`ifdef PARITY_CHECK_EN
    logic [DATA_W-1:0] acc_q;
    logic              mismatch_q;
    logic              err_q;
    logic              par_acc;
    logic              do_check;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= DECODE_ADDRESS;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic and combinational FIFO/source-side outputs.
    always_comb begin
        state_nx  = state;
        wr        = 1'b0;
        dout      = '0;
        lfd_state = 1'b0;
        busy      = 1'b0;
        pkt_done  = 1'b0;
        load_hdr  = 1'b0;
        dec_cnt   = 1'b0;
`ifdef PARITY_CHECK_EN
        par_acc   = 1'b0;
        do_check  = 1'b0;
`endif
        case (state)
            DECODE_ADDRESS: begin
                if (pkt_valid && (hdr_addr != 2'd3)) begin
                    load_hdr = 1'b1;
                    state_nx = pick(fifo_empty, hdr_addr) ? LOAD_FIRST_DATA
                                                          : WAIT_TILL_EMPTY;
                end
            end
            WAIT_TILL_EMPTY: begin
                busy = 1'b1;
                if (soft_hit) begin
                    state_nx = DECODE_ADDRESS;
                end else if (pick(fifo_empty, addr_q)) begin
                    state_nx = LOAD_FIRST_DATA;
                end
            end
            LOAD_FIRST_DATA: begin
                busy = 1'b1;
                if (soft_hit) begin
                    state_nx = DECODE_ADDRESS;
                end else if (!full_hit) begin
                    wr        = 1'b1;
                    dout      = hdr_q;
                    lfd_state = 1'b1;
                    state_nx  = (hdr_q[DATA_W-1:2] == '0) ? LOAD_PARITY : LOAD_DATA;
                end
            end
            LOAD_DATA: begin
                if (soft_hit) begin
                    busy     = 1'b1;
                    state_nx = DECODE_ADDRESS;
                end else begin
                    busy = full_hit;
                    if (pkt_valid && !full_hit) begin
                        wr      = 1'b1;
                        dout    = data_in;
                        dec_cnt = 1'b1;
                        if (cnt_q == LEN_W'(1)) begin
                            state_nx = LOAD_PARITY;
                        end
                    end
                end
            end
            LOAD_PARITY: begin
                if (soft_hit) begin
                    busy     = 1'b1;
                    state_nx = DECODE_ADDRESS;
                end else begin
                    busy = full_hit;
                    if (pkt_valid && !full_hit) begin
                        wr   = 1'b1;
                        dout = data_in;
`ifdef PARITY_CHECK_EN
                        par_acc  = 1'b1;
                        state_nx = CHECK_PARITY;
`else
                        pkt_done = 1'b1;
                        state_nx = DECODE_ADDRESS;
`endif
                    end
                end
            end
            CHECK_PARITY: begin
                busy     = 1'b1;
                state_nx = DECODE_ADDRESS;
                if (!soft_hit) begin
                    pkt_done = 1'b1;
`ifdef PARITY_CHECK_EN
                    do_check = 1'b1;
`endif
                end
            end
            default: begin
                state_nx = DECODE_ADDRESS;
            end
        endcase
    end

    // One-hot write enable toward the addressed FIFO.
    always_comb begin
        wt_en = 3'b000;
        if (wr) begin
            case (addr_q)
                2'd0:    wt_en = 3'b001;
                2'd1:    wt_en = 3'b010;
                2'd2:    wt_en = 3'b100;
                default: wt_en = 3'b000;
            endcase
        end
    end

    // Header register and remaining-payload counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hdr_q <= '0;
            cnt_q <= '0;
        end else if (load_hdr) begin
            hdr_q <= data_in;
            cnt_q <= data_in[DATA_W-1:2];
        end else if (dec_cnt) begin
            cnt_q <= cnt_q - LEN_W'(1);
        end
    end

`ifdef PARITY_CHECK_EN
    // Parity accumulator, per-packet mismatch flag and registered error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q      <= '0;
            mismatch_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (load_hdr) begin
                acc_q <= data_in;
            end else if (dec_cnt) begin
                acc_q <= acc_q ^ data_in;
            end
            if (par_acc) begin
                mismatch_q <= (data_in != acc_q);
            end
            if (do_check) begin
                err_q <= mismatch_q;
            end
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
